// File: rtl/gl_fb_writer.sv
// Framebuffer writer: drains the rasterizer pixel FIFO and writes each pixel
// to the framebuffer at y*RES_W + x, or fills the whole framebuffer with
// CLEAR_COLOR on request.
//
// Handshakes:
//   FIFO side  - rd_en pops one word; that word is on rd_data the following
//                cycle. rd_en is only raised in IDLE with empty=0, so at most
//                one word is ever in flight.
//   FB side    - fb_we/fb_addr/fb_data are registered and stay stable until
//                the cycle where fb_we && fb_ready, which is the transfer.
//
// State is visible as the enum `state`; busy mirrors (state != IDLE).
module gl_fb_writer #(
  parameter int          RES_W       = 640,
  parameter int          RES_H       = 480,
  parameter int          ADDR_W      = 19,
  parameter logic [17:0] CLEAR_COLOR = 18'h00000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              empty,
  output logic              rd_en,
  input  logic [95:0]       rd_data,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [17:0]       fb_data,
  output logic              fb_we,
  input  logic              fb_ready,
  input  logic              clear_req,
  output logic              busy,
  output logic [31:0]       pixel_count,
  output logic [15:0]       drop_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WRITE = 2'd2,
    CLEAR = 2'd3
  } state_t;

  state_t state;

  // Last framebuffer address; the clear sweep stops after this one is accepted.
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RES_W * RES_H - 1);
  localparam logic [ADDR_W-1:0] ROW_PITCH = ADDR_W'(RES_W);
  // Bounds one bit wider than the decoded fields so RES_W=1024 / RES_H=512 still compare correctly.
  localparam logic [10:0]       X_LIMIT   = 11'(RES_W);
  localparam logic [9:0]        Y_LIMIT   = 10'(RES_H);

  logic [9:0]        px_x;
  logic [8:0]        px_y;
  logic [17:0]       px_rgb;
  logic              px_legal;
  logic [ADDR_W-1:0] px_addr;

  // Bits of the FIFO word that carry nothing for this block.
  logic unused_bits;
  assign unused_bits = ^{rd_data[95:90], rd_data[79:73], rd_data[63:56],
                         rd_data[49:48], rd_data[41:40], rd_data[33:0]};

  // Decode the word presented on rd_data and form its linear address.
  always_comb begin
    px_x     = rd_data[89:80];
    px_y     = rd_data[72:64];
    px_rgb   = {rd_data[55:50], rd_data[47:42], rd_data[39:34]};
    px_legal = ({1'b0, px_x} < X_LIMIT) && ({1'b0, px_y} < Y_LIMIT);
    px_addr  = ADDR_W'(px_y) * ROW_PITCH + ADDR_W'(px_x);
  end

  // Pop strobe: decided in the IDLE cycle itself so the word lands in FETCH
  // one cycle later, giving the 3-cycle pixel cadence. A pending clear wins.
  assign rd_en = !rst && (state == IDLE) && !empty && !clear_req;

  assign busy = (state != IDLE);

  // Main sequencer: pixel fetch/write path, clear sweep and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      fb_addr     <= '0;
      fb_data     <= '0;
      fb_we       <= 1'b0;
      pixel_count <= '0;
      drop_count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (clear_req) begin
            fb_addr <= '0;
            fb_data <= CLEAR_COLOR;
            fb_we   <= 1'b1;
            state   <= CLEAR;
          end else if (!empty) begin
            state <= FETCH;
          end
        end

        FETCH: begin
          if (px_legal) begin
            fb_addr <= px_addr;
            fb_data <= px_rgb;
            fb_we   <= 1'b1;
            state   <= WRITE;
          end else begin
            if (drop_count != 16'hFFFF) begin
              drop_count <= drop_count + 16'd1;
            end
            state <= IDLE;
          end
        end

        WRITE: begin
          if (fb_ready) begin
            fb_we       <= 1'b0;
            pixel_count <= pixel_count + 32'd1;
            state       <= IDLE;
          end
        end

        CLEAR: begin
          if (fb_ready) begin
            if (fb_addr == LAST_ADDR) begin
              fb_we <= 1'b0;
              state <= IDLE;
            end else begin
              fb_addr <= fb_addr + 1'b1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gl_fb_writer.sv
// Testbench for gl_fb_writer on a reduced 40x30 screen so a full clear sweep
// stays short. Stimulus loads words into a small FIFO model; every expected
// framebuffer write is queued in exp_q and a monitor pops/compares on each
// accepted write (fb_we && fb_ready).
module tb_gl_fb_writer;

  localparam int          RES_W = 40;
  localparam int          RES_H = 30;
  localparam int          AW    = 11;
  localparam logic [17:0] CC    = 18'h2A5A5;
  localparam int          EW    = AW + 18;

  logic          clk = 1'b0;
  logic          rst;
  logic          empty;
  logic          rd_en;
  logic [95:0]   rd_data;
  logic [AW-1:0] fb_addr;
  logic [17:0]   fb_data;
  logic          fb_we;
  logic          fb_ready;
  logic          clear_req;
  logic          busy;
  logic [31:0]   pixel_count;
  logic [15:0]   drop_count;

  logic [95:0]   fifo_mem [256];
  logic [7:0]    push_cnt;
  logic [7:0]    pop_cnt = '0;

  logic [EW-1:0] exp_q[$];
  int            cmp_cnt;
  int            err_cnt;
  bit            done;

  gl_fb_writer #(
    .RES_W      (RES_W),
    .RES_H      (RES_H),
    .ADDR_W     (AW),
    .CLEAR_COLOR(CC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .empty      (empty),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .fb_addr    (fb_addr),
    .fb_data    (fb_data),
    .fb_we      (fb_we),
    .fb_ready   (fb_ready),
    .clear_req  (clear_req),
    .busy       (busy),
    .pixel_count(pixel_count),
    .drop_count (drop_count)
  );

  // Clock and reset-independent watchdog
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // FIFO model: word appears on rd_data the cycle after rd_en
  assign empty = (push_cnt == pop_cnt);

  always @(posedge clk) begin
    if (rd_en) begin
      rd_data <= fifo_mem[pop_cnt];
      pop_cnt <= pop_cnt + 8'd1;
    end
  end

  function automatic logic [95:0] mk_word(input int x, input int y,
                                          input logic [5:0] r, input logic [5:0] g,
                                          input logic [5:0] b);
    logic [95:0] w;
    w = 96'hF0F0_5A5A_C3C3_A5A5_3C3C_9696;
    w[89:80] = 10'(x);
    w[72:64] = 9'(y);
    w[55:50] = r;
    w[47:42] = g;
    w[39:34] = b;
    return w;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    cmp_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic load_word(input logic [95:0] w);
    fifo_mem[push_cnt] = w;
    push_cnt = push_cnt + 8'd1;
  endtask

  task automatic push_word(input logic [95:0] w);
    @(posedge clk);
    #2;
    load_word(w);
  endtask

  task automatic expect_write(input int addr, input logic [17:0] d);
    exp_q.push_back({AW'(addr), d});
  endtask

  task automatic wait_idle(input string name, input int max_cycles);
    done = 1'b0;
    for (int i = 0; i < max_cycles && !done; i++) begin
      @(negedge clk);
      if (!busy && empty && !fb_we) done = 1'b1;
    end
    if (!done) begin
      cmp_cnt++;
      err_cnt++;
      $display("FAIL %s: not idle after %0d cycles", name, max_cycles);
    end
  endtask

  // Scoreboard monitor: protocol checks plus in-order write comparison
  task automatic monitor();
    logic          stall_p;
    logic [AW-1:0] ha;
    logic [17:0]   hd;
    logic [EW-1:0] e;
    stall_p = 1'b0;
    ha = '0;
    hd = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_p = 1'b0;
      end else begin
        if (rd_en) check("rd_en_only_idle_nonempty", 64'({empty, busy}), 64'd0);
        if (stall_p) check("stall_hold", 64'({fb_we, fb_addr, fb_data}), 64'({1'b1, ha, hd}));
        if (fb_we && fb_ready) begin
          if (exp_q.size() == 0) begin
            cmp_cnt++;
            err_cnt++;
            $display("FAIL unexpected_write: got addr %0d data %h, none expected", fb_addr, fb_data);
          end else begin
            e = exp_q.pop_front();
            check("fb_write", 64'({fb_addr, fb_data}), 64'(e));
          end
        end
        stall_p = fb_we && !fb_ready;
        ha = fb_addr;
        hd = fb_data;
      end
    end
  endtask

  // Directed stimulus
  initial begin
    rst       = 1'b1;
    clear_req = 1'b0;
    fb_ready  = 1'b1;
    push_cnt  = '0;
    cmp_cnt   = 0;
    err_cnt   = 0;
    fork
      monitor();
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rd_en", rd_en, 0);
    check("rst_fb_we", fb_we, 0);
    check("rst_busy", busy, 0);
    check("rst_fb_addr", fb_addr, 0);
    check("rst_fb_data", fb_data, 0);
    check("rst_pixel_count", pixel_count, 0);
    check("rst_drop_count", drop_count, 0);
    @(posedge clk);
    #2 rst = 1'b0;

    // T1: single word, fb_ready high, exact latency
    expect_write(85, 18'h3F015);
    push_word(mk_word(5, 2, 6'h3F, 6'h00, 6'h15));
    @(negedge clk);
    check("t1_rd_en_N", rd_en, 1);
    @(negedge clk);
    check("t1_rd_en_N1", rd_en, 0);
    check("t1_busy_N1", busy, 1);
    @(negedge clk);
    check("t1_fb_we_N2", fb_we, 1);
    check("t1_fb_addr_N2", fb_addr, 85);
    check("t1_fb_data_N2", fb_data, 18'h3F015);
    @(negedge clk);
    check("t1_fb_we_N3", fb_we, 0);
    check("t1_busy_N3", busy, 0);
    check("t1_pixel_count", pixel_count, 1);

    // T2: stalled write, second word queued behind it
    @(posedge clk);
    #2 fb_ready = 1'b0;
    expect_write(85, 18'h3F015);
    expect_write(127, 18'h01ABC);
    push_word(mk_word(5, 2, 6'h3F, 6'h00, 6'h15));
    push_word(mk_word(7, 3, 6'h01, 6'h2A, 6'h3C));
    @(negedge clk);
    check("t2_no_pop_fetch", rd_en, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t2_stall_we", fb_we, 1);
      check("t2_stall_addr", fb_addr, 85);
      check("t2_stall_no_pop", rd_en, 0);
    end
    @(posedge clk);
    #2 fb_ready = 1'b1;
    wait_idle("t2_idle", 20);
    check("t2_pixel_count", pixel_count, 3);

    // T3: out-of-range words dropped, corner pixel written
    expect_write(RES_W * RES_H - 1, 18'h2A57F);
    push_word(mk_word(RES_W, 0, 6'h3F, 6'h3F, 6'h3F));
    push_word(mk_word(0, RES_H, 6'h3F, 6'h3F, 6'h3F));
    push_word(mk_word(1023, 5, 6'h3F, 6'h3F, 6'h3F));
    push_word(mk_word(RES_W - 1, RES_H - 1, 6'h2A, 6'h15, 6'h3F));
    wait_idle("t3_idle", 40);
    check("t3_drop_count", drop_count, 3);
    check("t3_pixel_count", pixel_count, 4);

    // T4: clear with FIFO non-empty and fb_ready toggling
    for (int i = 0; i < RES_W * RES_H; i++) expect_write(i, CC);
    expect_write(0, 18'h01083);
    expect_write(620, 18'h10830);
    @(posedge clk);
    #2;
    clear_req = 1'b1;
    load_word(mk_word(0, 0, 6'h01, 6'h02, 6'h03));
    load_word(mk_word(20, 15, 6'h10, 6'h20, 6'h30));
    done = 1'b0;
    for (int i = 0; i < 10 && !done; i++) begin
      @(negedge clk);
      if (busy) done = 1'b1;
    end
    check("t4_busy_seen", busy, 1);
    @(posedge clk);
    #2 clear_req = 1'b0;
    done = 1'b0;
    for (int c = 0; c < 5000 && !done; c++) begin
      @(posedge clk);
      #2;
      fb_ready = ~fb_ready;
      if (!busy) done = 1'b1;
    end
    if (!done) begin
      cmp_cnt++;
      err_cnt++;
      $display("FAIL t4_clear_timeout: busy still %0d after 5000 cycles", busy);
    end
    fb_ready = 1'b1;
    wait_idle("t4_idle", 40);
    check("t4_pixel_count", pixel_count, 6);
    check("t4_drop_count", drop_count, 3);

    // T5: reset while stalled in WRITE
    @(posedge clk);
    #2 fb_ready = 1'b0;
    expect_write(41, 18'h118B3);
    push_word(mk_word(1, 1, 6'h11, 6'h22, 6'h33));
    push_word(mk_word(2, 0, 6'h00, 6'h3F, 6'h00));
    done = 1'b0;
    for (int i = 0; i < 10 && !done; i++) begin
      @(negedge clk);
      if (fb_we) done = 1'b1;
    end
    check("t5_in_write", fb_we, 1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    void'(exp_q.pop_back());
    @(posedge clk);
    @(negedge clk);
    check("t5_rst_fb_we", fb_we, 0);
    check("t5_rst_rd_en", rd_en, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_pixel_count", pixel_count, 0);
    check("t5_rst_drop_count", drop_count, 0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    fb_ready = 1'b1;
    expect_write(2, 18'h00FC0);
    wait_idle("t5_restart", 20);
    check("t5_pixel_count", pixel_count, 1);

    // T6: FIFO empty for 100 cycles
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("t6_quiet", 64'({rd_en, fb_we, busy}), 0);
    end

    @(negedge clk);
    check("exp_q_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
